// File: rtl/enigma_defs.sv
// Shared constants, FSM state encoding and letter/index helpers
// for the Enigma keystroke path.
package enigma_defs;

  localparam logic [7:0] ASCII_A       = 8'h41;
  localparam int         ALPHABET_SIZE = 26;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_STEP = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_OUT  = 3'd4
  } seq_state_e;

  function automatic logic [4:0] char_to_idx(
    input logic [7:0] c
  );
    return 5'(c - ASCII_A);
  endfunction

  function automatic logic [7:0] idx_to_char(
    input logic [4:0] i
  );
    return ASCII_A + {3'b000, i};
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO holding pending key characters.
// Push is refused when full, pop is refused when empty.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        empty,
  output logic        full,
  output logic [AW:0] count
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wr, rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];
  assign wr    = push & ~full;
  assign rd    = pop & ~empty;

  // Pointers are AW bits wide, so they wrap for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr, rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (wr) mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/keystroke_sequencer.sv
// Queues accepted key releases and runs each one through
// rotor step, encode request, and ciphertext output.
module keystroke_sequencer
  import enigma_defs::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int FIFO_AW     = 2,
  parameter int ENC_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_ok,
  input  logic [7:0] key_char,
  output logic       step_pulse,
  output logic       enc_valid,
  input  logic       enc_ready,
  output logic [4:0] enc_index,
  input  logic       enc_done,
  input  logic [4:0] enc_result,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_char,
  output logic       busy,
  output logic       overflow,
  input  logic       clear_err,
  output logic       timeout_err
);

  localparam int TW = $clog2(ENC_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(ENC_TIMEOUT);

  seq_state_e state_q, state_d;

  logic [4:0]    cur_idx_q, cur_idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          step_q, step_d;
  logic          enc_valid_q, enc_valid_d;
  logic [4:0]    enc_index_q, enc_index_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_char_q, out_char_d;
  logic          overflow_q, overflow_d;
  logic          timeout_q, timeout_d;

  logic           pop;
  logic           to_set;
  logic [7:0]     head;
  logic           empty, full;
  logic [FIFO_AW:0] count;

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (key_ok),
    .pop     (pop),
    .din     (key_char),
    .dout    (head),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  always_comb begin
    state_d     = state_q;
    cur_idx_d   = cur_idx_q;
    timer_d     = timer_q;
    step_d      = 1'b0;
    enc_valid_d = enc_valid_q;
    enc_index_d = enc_index_q;
    out_valid_d = out_valid_q;
    out_char_d  = out_char_q;
    pop         = 1'b0;
    to_set      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          cur_idx_d = char_to_idx(head);
          step_d    = 1'b1;
          state_d   = ST_STEP;
        end
      end
      ST_STEP: begin
        enc_valid_d = 1'b1;
        enc_index_d = cur_idx_q;
        state_d     = ST_REQ;
      end
      ST_REQ: begin
        if (enc_ready) begin
          enc_valid_d = 1'b0;
          enc_index_d = '0;
          timer_d     = '0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The key is abandoned on the cycle the count reaches the limit.
        if (enc_done) begin
          out_valid_d = 1'b1;
          out_char_d  = idx_to_char(enc_result);
          state_d     = ST_OUT;
        end else if (timer_q + TW'(1) == TMAX) begin
          to_set  = 1'b1;
          timer_d = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_char_d  = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    overflow_d = (key_ok & full) | (overflow_q & ~clear_err);
    timeout_d  = to_set | (timeout_q & ~clear_err);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cur_idx_q   <= '0;
      timer_q     <= '0;
      step_q      <= 1'b0;
      enc_valid_q <= 1'b0;
      enc_index_q <= '0;
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_idx_q   <= cur_idx_d;
      timer_q     <= timer_d;
      step_q      <= step_d;
      enc_valid_q <= enc_valid_d;
      enc_index_q <= enc_index_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      overflow_q  <= overflow_d;
      timeout_q   <= timeout_d;
    end
  end

  assign step_pulse  = step_q;
  assign enc_valid   = enc_valid_q;
  assign enc_index   = enc_index_q;
  assign out_valid   = out_valid_q;
  assign out_char    = out_char_q;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_q;
  assign busy        = (state_q != ST_IDLE) | (count != '0);

endmodule

// File: tb/tb_keystroke_sequencer.sv
// Directed and randomized checks of keystroke_sequencer against
// a queue-based model of key order, step count and encode results.
module tb_keystroke_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_ok = 1'b0;
  logic [7:0] key_char = '0;
  logic       step_pulse;
  logic       enc_valid;
  logic       enc_ready = 1'b0;
  logic [4:0] enc_index;
  logic       enc_done = 1'b0;
  logic [4:0] enc_result = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_char;
  logic       busy;
  logic       overflow;
  logic       clear_err = 1'b0;
  logic       timeout_err;

  keystroke_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_ok      (key_ok),
    .key_char    (key_char),
    .step_pulse  (step_pulse),
    .enc_valid   (enc_valid),
    .enc_ready   (enc_ready),
    .enc_index   (enc_index),
    .enc_done    (enc_done),
    .enc_result  (enc_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_char    (out_char),
    .busy        (busy),
    .overflow    (overflow),
    .clear_err   (clear_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  bit ready_en  = 1'b1;
  bit done_en   = 1'b1;
  bit oready_en = 1'b1;
  bit rnd       = 1'b0;
  int force_res = -1;
  int dcnt      = 0;
  bit pend      = 1'b0;
  int nstep     = 0;
  bit prev_step = 1'b0;

  logic [4:0] exp_idx[$];
  logic [4:0] got_idx[$];
  logic [4:0] exp_res[$];
  logic [7:0] got_chr[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // One clock: log handshakes, advance, then play encoder/consumer.
  task automatic cyc();
    if (enc_valid && enc_ready) begin
      got_idx.push_back(enc_index);
      pend = 1'b1;
      dcnt = rnd ? int'($urandom_range(0, 4)) : 0;
    end
    if (out_valid && out_ready) got_chr.push_back(out_char);
    @(posedge clk);
    #1;
    if (step_pulse) nstep++;
    chk("step_one_cycle", 32'(step_pulse & prev_step), 0);
    prev_step = step_pulse;
    if (!enc_valid) chk("idx_zero_idle", enc_index, 0);
    if (!out_valid) chk("chr_zero_idle", out_char, 0);
    key_ok   = 1'b0;
    enc_done = 1'b0;
    if (pend && done_en) begin
      if (dcnt == 0) begin
        enc_done   = 1'b1;
        enc_result = (force_res >= 0) ? 5'(force_res)
                   : 5'($urandom_range(0, 25));
        exp_res.push_back(enc_result);
        pend = 1'b0;
      end else begin
        dcnt--;
      end
    end
    enc_ready = rnd ? 1'($urandom_range(0, 1)) : ready_en;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : oready_en;
  endtask

  task automatic send(input logic [7:0] c, input bit acc);
    key_ok   = 1'b1;
    key_char = c;
    if (acc) exp_idx.push_back(5'(c - 8'h41));
    cyc();
  endtask

  task automatic drain(input string tag);
    int b = 0;
    rnd = 1'b0;
    ready_en  = 1'b1;
    oready_en = 1'b1;
    do begin
      cyc();
      b++;
    end while (busy && b < 3000);
    chk({tag, "_drain"}, 32'(busy), 0);
  endtask

  task automatic wait_hs(input string tag, input int n);
    int b = 0;
    while (got_idx.size() < n && b < 100) begin
      cyc();
      b++;
    end
    chk({tag, "_hs"}, got_idx.size(), n);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_nidx"}, got_idx.size(), exp_idx.size());
    foreach (exp_idx[i])
      if (i < got_idx.size())
        chk({tag, "_idx"}, got_idx[i], exp_idx[i]);
    chk({tag, "_nchr"}, got_chr.size(), exp_res.size());
    foreach (exp_res[i])
      if (i < got_chr.size())
        chk({tag, "_chr"}, got_chr[i], 8'h41 + 8'(exp_res[i]));
    exp_idx.delete();
    got_idx.delete();
    exp_res.delete();
    got_chr.delete();
  endtask

  initial begin
    int s;
    int w;
    logic [7:0] held;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_step", step_pulse, 0);
    chk("rst_encv", enc_valid, 0);
    chk("rst_outv", out_valid, 0);
    chk("rst_outc", out_char, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_tmo", timeout_err, 0);
    reset_n   = 1'b1;
    enc_ready = 1'b1;
    out_ready = 1'b1;
    cyc();
    cyc();

    // single key with immediate handshakes
    force_res = 7;
    s = nstep;
    send("C", 1'b1);
    chk("t1_busy_c1", busy, 1);
    chk("t1_nostep_c1", step_pulse, 0);
    cyc();
    chk("t1_step_c2", step_pulse, 1);
    cyc();
    chk("t1_req_c3", enc_valid, 1);
    chk("t1_idx_c3", enc_index, 2);
    cyc();
    chk("t1_noout_c4", out_valid, 0);
    cyc();
    chk("t1_outv_c5", out_valid, 1);
    chk("t1_char_c5", out_char, "H");
    cyc();
    chk("t1_outv_c6", out_valid, 0);
    chk("t1_idle_c6", busy, 0);
    chk("t1_nstep", nstep - s, 1);
    force_res = -1;
    check_stream("t1");

    // burst behind a stalled encoder
    ready_en  = 1'b0;
    enc_ready = 1'b0;
    s = nstep;
    send("A", 1'b1);
    send("B", 1'b1);
    send("C", 1'b1);
    send("D", 1'b1);
    repeat (6) cyc();
    chk("t2_ovf", overflow, 0);
    drain("t2");
    chk("t2_nstep", nstep - s, 4);
    chk("t2_ovf_end", overflow, 0);
    check_stream("t2");

    // overflow: encoder stalls on Z while five more arrive
    ready_en  = 1'b0;
    enc_ready = 1'b0;
    s = nstep;
    send("Z", 1'b1);
    repeat (3) cyc();
    chk("t3_req", enc_valid, 1);
    send("E", 1'b1);
    send("F", 1'b1);
    send("G", 1'b1);
    send("H", 1'b1);
    chk("t3_ovf_pre", overflow, 0);
    send("I", 1'b0);
    chk("t3_ovf", overflow, 1);
    drain("t3");
    chk("t3_nstep", nstep - s, 5);
    check_stream("t3");
    clear_err = 1'b1;
    cyc();
    clear_err = 1'b0;
    chk("t3_clear", overflow, 0);

    // encoder timeout, next key still processed
    done_en = 1'b0;
    s = nstep;
    send("X", 1'b1);
    send("Y", 1'b1);
    wait_hs("t4", 1);
    w = 0;
    do begin
      cyc();
      w++;
    end while (!timeout_err && w < 400);
    chk("t4_wait_cycles", w, 255);
    chk("t4_encv", enc_valid, 0);
    chk("t4_outv", out_valid, 0);
    chk("t4_busy", busy, 1);
    done_en = 1'b1;
    pend    = 1'b0;
    cyc();
    chk("t4_next_step", step_pulse, 1);
    drain("t4");
    chk("t4_nstep", nstep - s, 2);
    chk("t4_sticky", timeout_err, 1);
    check_stream("t4");
    clear_err = 1'b1;
    cyc();
    clear_err = 1'b0;
    chk("t4_clear", timeout_err, 0);

    // output backpressure
    oready_en = 1'b0;
    out_ready = 1'b0;
    send("M", 1'b1);
    send("N", 1'b1);
    w = 0;
    while (!out_valid && w < 100) begin
      cyc();
      w++;
    end
    chk("t5_outv", out_valid, 1);
    held = out_char;
    s = nstep;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("t5_hold_v", out_valid, 1);
      chk("t5_hold_c", out_char, held);
    end
    chk("t5_nostep", nstep - s, 0);
    drain("t5");
    chk("t5_nstep", nstep - s, 1);
    check_stream("t5");

    // reset while waiting on the encoder
    done_en = 1'b0;
    send("Q", 1'b1);
    wait_hs("t6", 1);
    repeat (3) cyc();
    reset_n = 1'b0;
    #1;
    chk("t6_step", step_pulse, 0);
    chk("t6_encv", enc_valid, 0);
    chk("t6_idx", enc_index, 0);
    chk("t6_outv", out_valid, 0);
    chk("t6_outc", out_char, 0);
    chk("t6_busy", busy, 0);
    cyc();
    reset_n = 1'b1;
    pend    = 1'b0;
    enc_done   = 1'b1;
    enc_result = 5'd3;
    cyc();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_stale_outv", out_valid, 0);
      chk("t6_stale_busy", busy, 0);
    end
    done_en = 1'b1;
    check_stream("t6");

    // random keys and random handshake timing
    rnd = 1'b1;
    s = nstep;
    for (int k = 0; k < 40; k++) begin
      int b = 0;
      while (exp_idx.size() - got_chr.size() >= 4 && b < 500) begin
        cyc();
        b++;
      end
      chk("rnd_progress", 32'(b < 500), 1);
      repeat ($urandom_range(0, 2)) cyc();
      send(8'h41 + 8'($urandom_range(0, 25)), 1'b1);
    end
    drain("rnd");
    chk("rnd_nstep", nstep - s, 40);
    chk("rnd_ovf", overflow, 0);
    chk("rnd_tmo", timeout_err, 0);
    check_stream("rnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
